// File: rtl/axi_lite_master_fsm_pkg.sv
// Shared AXI-Lite master definitions: one-hot state codes,
// response codes, lane count and a lane-mask helper.
package axi_defs;

  localparam int LANES = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int I_IDLE    = 0;
  localparam int I_WR_REQ  = 1;
  localparam int I_WR_RESP = 2;
  localparam int I_RD_ADDR = 3;
  localparam int I_RD_DATA = 4;
  localparam int I_DONE    = 5;

  localparam logic [5:0] OH_IDLE    = 6'(1 << I_IDLE);
  localparam logic [5:0] OH_WR_REQ  = 6'(1 << I_WR_REQ);
  localparam logic [5:0] OH_WR_RESP = 6'(1 << I_WR_RESP);
  localparam logic [5:0] OH_RD_ADDR = 6'(1 << I_RD_ADDR);
  localparam logic [5:0] OH_RD_DATA = 6'(1 << I_RD_DATA);
  localparam logic [5:0] OH_DONE    = 6'(1 << I_DONE);

  typedef enum logic [5:0] {
    ST_IDLE    = OH_IDLE,
    ST_WR_REQ  = OH_WR_REQ,
    ST_WR_RESP = OH_WR_RESP,
    ST_RD_ADDR = OH_RD_ADDR,
    ST_RD_DATA = OH_RD_DATA,
    ST_DONE    = OH_DONE
  } state_t;

  // Expand a byte-lane mask into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(
    input logic [LANES-1:0] strb
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++)
      m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/axi_lite_master_fsm_if.sv
// AXI-Lite AW/W/B/AR/R channel bundle.
// master: drives M_* / samples S_*; slave: the reverse.
interface axi_lite_master_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              M_AWVALID;
  logic [ADDR_W-1:0] M_AWADDR;
  logic              S_AWREADY;
  logic              M_WVALID;
  logic [DATA_W-1:0] M_WDATA;
  logic [3:0]        M_WSTRB;
  logic              S_WREADY;
  logic              M_BREADY;
  logic              S_BVALID;
  logic [1:0]        S_BRESP;
  logic              M_ARVALID;
  logic [ADDR_W-1:0] M_ARADDR;
  logic              S_ARREADY;
  logic              M_RREADY;
  logic [3:0]        M_BLEN;
  logic              S_RVALID;
  logic [DATA_W-1:0] S_RDATA;

  modport master (
    output M_AWVALID, M_AWADDR,
    output M_WVALID, M_WDATA, M_WSTRB,
    output M_BREADY,
    output M_ARVALID, M_ARADDR,
    output M_RREADY, M_BLEN,
    input  S_AWREADY, S_WREADY,
    input  S_BVALID, S_BRESP,
    input  S_ARREADY,
    input  S_RVALID, S_RDATA
  );

  modport slave (
    input  M_AWVALID, M_AWADDR,
    input  M_WVALID, M_WDATA, M_WSTRB,
    input  M_BREADY,
    input  M_ARVALID, M_ARADDR,
    input  M_RREADY, M_BLEN,
    output S_AWREADY, S_WREADY,
    output S_BVALID, S_BRESP,
    output S_ARREADY,
    output S_RVALID, S_RDATA
  );
endinterface

// File: rtl/axi_lite_master_fsm_wdog.sv
// Per-state watchdog: clk, rst, clear, enable, limit in;
// expired out. limit==0 disables it.
module axi_watchdog_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      r_cnt <= '0;
    else if (enable && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  // Fires in the cycle whose edge brings the count to limit,
  // so the owner's outputs drop after limit cycles in state.
  assign expired = enable && (limit != '0) &&
                   (r_cnt == limit - 1'b1);

endmodule

// File: rtl/axi_lite_master_fsm.sv
// Single-outstanding AXI-Lite master: cmd/rsp in, AXI channels
// out via bus (master modport). Macro: AXI_MASTER_BRESP_WAIT_EN.
// Ports: M_ACLK, M_ARESET (sync high), cmd_valid/ready/write/
// addr/wdata/strb, rsp_valid/rdata/err, bus.
module axi_lite_master_fsm
  import axi_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              M_ACLK,
  input  logic              M_ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  axi_lite_master_fsm_if.master bus
);

  state_t            r_state, w_state_n;
  logic              r_cmd_ready, w_cmd_ready_n;
  logic              r_rsp_valid, w_rsp_valid_n;
  logic              r_rsp_err, w_rsp_err_n;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_n;
  logic              r_awvalid, w_awvalid_n;
  logic [ADDR_W-1:0] r_awaddr, w_awaddr_n;
  logic              r_wvalid, w_wvalid_n;
  logic [DATA_W-1:0] r_wdata, w_wdata_n;
  logic [3:0]        r_wstrb, w_wstrb_n;
  logic              r_bready, w_bready_n;
  logic              r_arvalid, w_arvalid_n;
  logic [ADDR_W-1:0] r_araddr, w_araddr_n;
  logic              r_rready, w_rready_n;
  logic [3:0]        r_blen, w_blen_n;

  logic              w_aw_hs, w_w_hs;
  logic              w_busy, w_clear, w_expired;
  logic [DATA_W-1:0] w_rd_word;

  assign w_aw_hs = r_awvalid && bus.S_AWREADY;
  assign w_w_hs  = r_wvalid && bus.S_WREADY;
  assign w_rd_word = bus.S_RDATA &
                     DATA_W'(lane_mask(r_blen));

  assign w_busy = r_state[I_WR_REQ] | r_state[I_WR_RESP] |
                  r_state[I_RD_ADDR] | r_state[I_RD_DATA];
  assign w_clear = (w_state_n != r_state);

`ifndef AXI_MASTER_BRESP_WAIT_EN
  logic w_unused_b;
  assign w_unused_b = ^{bus.S_BVALID, bus.S_BRESP};
`endif

  axi_watchdog_cnt #(.CNT_W(16)) u_wdog (
    .clk     (M_ACLK),
    .rst     (M_ARESET),
    .clear   (w_clear),
    .enable  (w_busy),
    .limit   (16'(TIMEOUT)),
    .expired (w_expired)
  );

  always_comb begin
    w_state_n     = r_state;
    w_cmd_ready_n = 1'b0;
    w_rsp_valid_n = 1'b0;
    w_rsp_err_n   = 1'b0;
    w_rsp_rdata_n = r_rsp_rdata;
    w_awvalid_n   = r_awvalid;
    w_awaddr_n    = r_awaddr;
    w_wvalid_n    = r_wvalid;
    w_wdata_n     = r_wdata;
    w_wstrb_n     = r_wstrb;
    w_bready_n    = r_bready;
    w_arvalid_n   = r_arvalid;
    w_araddr_n    = r_araddr;
    w_rready_n    = r_rready;
    w_blen_n      = r_blen;

    unique case (1'b1)
      r_state[I_IDLE]: begin
        if (cmd_valid && r_cmd_ready) begin
          if (cmd_write) begin
            w_state_n   = ST_WR_REQ;
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
            w_awaddr_n  = cmd_addr;
            w_wdata_n   = cmd_wdata;
            w_wstrb_n   = cmd_strb;
          end else begin
            w_state_n   = ST_RD_ADDR;
            w_arvalid_n = 1'b1;
            w_araddr_n  = cmd_addr;
            w_blen_n    = cmd_strb;
          end
        end else begin
          w_cmd_ready_n = 1'b1;
        end
      end

      r_state[I_WR_REQ]: begin
        if (w_aw_hs) w_awvalid_n = 1'b0;
        if (w_w_hs)  w_wvalid_n  = 1'b0;
        if ((!r_awvalid || w_aw_hs) &&
            (!r_wvalid || w_w_hs)) begin
          w_state_n = ST_WR_RESP;
`ifdef AXI_MASTER_BRESP_WAIT_EN
          w_bready_n = 1'b1;
`endif
        end
      end

      r_state[I_WR_RESP]: begin
`ifdef AXI_MASTER_BRESP_WAIT_EN
        if (bus.S_BVALID && r_bready) begin
          w_bready_n    = 1'b0;
          w_rsp_err_n   = (bus.S_BRESP != AXI_RESP_OKAY);
          w_rsp_valid_n = 1'b1;
          w_state_n     = ST_DONE;
        end
`else
        w_rsp_valid_n = 1'b1;
        w_state_n     = ST_DONE;
`endif
      end

      r_state[I_RD_ADDR]: begin
        if (r_arvalid && bus.S_ARREADY) begin
          w_arvalid_n = 1'b0;
          // Data alongside ARREADY is taken right away.
          if (bus.S_RVALID) begin
            w_rsp_rdata_n = w_rd_word;
            w_rsp_valid_n = 1'b1;
            w_state_n     = ST_DONE;
          end else begin
            w_rready_n = 1'b1;
            w_state_n  = ST_RD_DATA;
          end
        end
      end

      r_state[I_RD_DATA]: begin
        if (bus.S_RVALID && r_rready) begin
          w_rsp_rdata_n = w_rd_word;
          w_rready_n    = 1'b0;
          w_rsp_valid_n = 1'b1;
          w_state_n     = ST_DONE;
        end
      end

      r_state[I_DONE]: begin
        w_state_n     = ST_IDLE;
        w_cmd_ready_n = 1'b1;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // A handshake in the expiry cycle wins over the abort.
    if (w_expired && (w_state_n == r_state)) begin
      w_awvalid_n   = 1'b0;
      w_wvalid_n    = 1'b0;
      w_bready_n    = 1'b0;
      w_arvalid_n   = 1'b0;
      w_rready_n    = 1'b0;
      w_rsp_rdata_n = '0;
      w_rsp_err_n   = 1'b1;
      w_rsp_valid_n = 1'b1;
      w_state_n     = ST_DONE;
    end
  end

  always_ff @(posedge M_ACLK) begin
    if (M_ARESET) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
      r_blen      <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cmd_ready <= w_cmd_ready_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_err   <= w_rsp_err_n;
      r_rsp_rdata <= w_rsp_rdata_n;
      r_awvalid   <= w_awvalid_n;
      r_awaddr    <= w_awaddr_n;
      r_wvalid    <= w_wvalid_n;
      r_wdata     <= w_wdata_n;
      r_wstrb     <= w_wstrb_n;
      r_bready    <= w_bready_n;
      r_arvalid   <= w_arvalid_n;
      r_araddr    <= w_araddr_n;
      r_rready    <= w_rready_n;
      r_blen      <= w_blen_n;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_err       = r_rsp_err;
  assign rsp_rdata     = r_rsp_rdata;
  assign bus.M_AWVALID = r_awvalid;
  assign bus.M_AWADDR  = r_awaddr;
  assign bus.M_WVALID  = r_wvalid;
  assign bus.M_WDATA   = r_wdata;
  assign bus.M_WSTRB   = r_wstrb;
  assign bus.M_BREADY  = r_bready;
  assign bus.M_ARVALID = r_arvalid;
  assign bus.M_ARADDR  = r_araddr;
  assign bus.M_RREADY  = r_rready;
  assign bus.M_BLEN    = r_blen;

endmodule

// File: tb/tb_axi_lite_master_fsm.sv
// Bench for axi_lite_master_fsm: cycle-level slave plus a
// byte-array reference memory, directed and random accesses.
module tb_axi_lite_master_fsm;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad = 0;

  logic [7:0] smem [16];
  logic [7:0] rmem [16];

  always #5 clk = ~clk;

  axi_lite_master_fsm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_master_fsm #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .M_ACLK    (clk),
    .M_ARESET  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int base_of(input logic [31:0] a);
    return int'(a[3:2]) * 4;
  endfunction

  function automatic logic [31:0] ref_read(
    input logic [31:0] a, input logic [3:0] s);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < 4; i++)
      if (s[i]) v[8*i +: 8] = rmem[base_of(a) + i];
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) rmem[base_of(a) + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] slv_word(input logic [31:0] a);
    int b;
    b = base_of(a);
    return {smem[b+3], smem[b+2], smem[b+1], smem[b]};
  endfunction

  task automatic slv_idle();
    bus.S_AWREADY = 0; bus.S_WREADY = 0;
    bus.S_BVALID = 0; bus.S_BRESP = 0;
    bus.S_ARREADY = 0; bus.S_RVALID = 0;
    bus.S_RDATA = 0;
  endtask

  task automatic run_txn(
    input logic wr, input logic [31:0] a, d,
    input logic [3:0] s,
    input int aw_d, w_d, ar_d, r_d, b_d,
    input logic [1:0] br,
    input logic same, stuck, rst_mid);
    int awc = 0, wc = 0, arc = 0, rc = 0, bc = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, r_got = 0;
    int b_hs = 0, brdy = 0, arv_cyc = 0, both = 0;
    int badhold = 0, pulses = 0;
    logic [31:0] cap_a = 0, cap_d = 0, rdw = 0;
    logic [3:0] cap_s = 0;
    logic got_a = 0, got_d = 0, done = 0, hit = 0;
    logic got_err = 0, exp_err;
    logic [31:0] got_rd = 0, exp_rd;

    exp_rd = (wr || stuck) ? 32'h0 : ref_read(a, s);
`ifdef AXI_MASTER_BRESP_WAIT_EN
    exp_err = stuck ? 1'b1 : (wr && (br != 2'b00));
`else
    exp_err = stuck;
`endif

    cmd_valid = 1; cmd_write = wr;
    cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    for (int i = 0; i < 10 && cmd_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("cmd_ready", {31'b0, cmd_ready}, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = 4'($urandom); cmd_write = 1'($urandom);

    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0)
        chk("issue",
            {29'b0, bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID},
            wr ? 32'h6 : 32'h1);
      if (pulses > 0) begin
        chk("rsp_single", {31'b0, rsp_valid}, 0);
        chk("ready_after", {31'b0, cmd_ready}, 1);
        done = 1;
        break;
      end
      if (rsp_valid) begin
        pulses++; got_err = rsp_err; got_rd = rsp_rdata;
      end
      if (rst_mid && bus.M_RREADY) begin
        slv_idle();
        rst = 1; @(posedge clk); #1;
        chk("rst_ctl", {24'b0, cmd_ready, rsp_valid, rsp_err,
            bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY,
            bus.M_ARVALID, bus.M_RREADY}, 0);
        chk("rst_araddr", bus.M_ARADDR, 0);
        chk("rst_blen", {28'b0, bus.M_BLEN}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 0; @(posedge clk); #1;
        chk("rst_rel_ready", {31'b0, cmd_ready}, 1);
        chk("rst_rel_rsp", {31'b0, rsp_valid}, 0);
        hit = 1;
        break;
      end
      if (bus.M_ARVALID && (bus.M_AWVALID || bus.M_WVALID))
        both++;
      if (bus.M_AWVALID && bus.M_AWADDR !== a) badhold++;
      if (bus.M_WVALID && (bus.M_WDATA !== d ||
          bus.M_WSTRB !== s)) badhold++;
      if (bus.M_ARVALID && (bus.M_ARADDR !== a ||
          bus.M_BLEN !== s)) badhold++;
      if (bus.M_ARVALID) arv_cyc++;
      if (bus.M_BREADY) brdy++;

      bus.S_AWREADY = bus.M_AWVALID && (awc >= aw_d);
      if (bus.M_AWVALID) awc++;
      if (bus.M_AWVALID && bus.S_AWREADY) begin
        aw_hs++; cap_a = bus.M_AWADDR; got_a = 1;
      end
      bus.S_WREADY = bus.M_WVALID && (wc >= w_d);
      if (bus.M_WVALID) wc++;
      if (bus.M_WVALID && bus.S_WREADY) begin
        w_hs++; cap_d = bus.M_WDATA; cap_s = bus.M_WSTRB;
        got_d = 1;
      end
      if (got_a && got_d) begin
        for (int i = 0; i < 4; i++)
          if (cap_s[i])
            smem[base_of(cap_a) + i] = cap_d[8*i +: 8];
        got_a = 0; got_d = 0;
      end

      bus.S_ARREADY = bus.M_ARVALID && !stuck &&
                      (arc >= ar_d);
      if (bus.M_ARVALID) arc++;
      if (bus.M_ARVALID && bus.S_ARREADY) begin
        ar_hs++; rdw = slv_word(bus.M_ARADDR);
      end
      bus.S_RVALID = (same && bus.S_ARREADY) ||
                     (bus.M_RREADY && (rc >= r_d));
      if (bus.M_RREADY) rc++;
      bus.S_RDATA = bus.S_RVALID ? rdw : $urandom;
      if (bus.S_RVALID) r_got++;

`ifdef AXI_MASTER_BRESP_WAIT_EN
      bus.S_BVALID = bus.M_BREADY && (bc >= b_d);
`else
      bus.S_BVALID = 1'b0;
`endif
      if (bus.M_BREADY) bc++;
      bus.S_BRESP = bus.S_BVALID ? br : 2'($urandom);
      if (bus.M_BREADY && bus.S_BVALID) b_hs++;

      @(posedge clk); #1;
    end
    slv_idle();

    if (rst_mid) begin
      chk("rst_hit", {31'b0, hit}, 1);
      return;
    end
    chk("rsp_seen", {31'b0, done}, 1);
    chk("rsp_err", {31'b0, got_err}, {31'b0, exp_err});
    chk("no_overlap", both, 0);
    chk("held", badhold, 0);
    if (wr) begin
      ref_write(a, d, s);
      chk("aw_hs", aw_hs, 1);
      chk("w_hs", w_hs, 1);
`ifdef AXI_MASTER_BRESP_WAIT_EN
      chk("b_hs", b_hs, 1);
`else
      chk("bready_low", brdy, 0);
`endif
      for (int k = 0; k < 16; k += 4)
        chk("mem", slv_word(32'(k)), {rmem[k+3], rmem[k+2],
            rmem[k+1], rmem[k]});
    end else begin
      chk("rsp_rdata", got_rd, exp_rd);
      chk("ar_hs", ar_hs, stuck ? 0 : 1);
      chk("r_beats", r_got, stuck ? 0 : 1);
      if (stuck) chk("arv_cycles", arv_cyc, TO);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  logic        q_wr, q_same;
  logic [31:0] q_a, q_d;
  logic [3:0]  q_s;
  logic [1:0]  q_br;

  initial begin
    rst = 1; cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
    slv_idle();
    for (int i = 0; i < 16; i++) begin
      smem[i] = 0; rmem[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {24'b0, cmd_ready, rsp_valid, rsp_err,
        bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY,
        bus.M_ARVALID, bus.M_RREADY}, 0);
    chk("reset_addr", bus.M_AWADDR | bus.M_ARADDR, 0);
    chk("reset_data", bus.M_WDATA | rsp_rdata, 0);
    chk("reset_lanes", {24'b0, bus.M_WSTRB, bus.M_BLEN}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("ready_post_reset", {31'b0, cmd_ready}, 1);

    run_txn(1, 32'h0, 32'hA5A5_1234, 4'hF,
            2, 2, 0, 0, 1, 2'b00, 0, 0, 0);
    chk("mem0_bytes", slv_word(32'h0), 32'hA5A5_1234);

    {smem[3], smem[2], smem[1], smem[0]} = 32'hDEAD_BEEF;
    {rmem[3], rmem[2], rmem[1], rmem[0]} = 32'hDEAD_BEEF;
    run_txn(0, 32'h0, 32'h0, 4'h3,
            0, 0, 1, 1, 0, 2'b00, 0, 0, 0);
    chk("read_beef", rsp_rdata, 32'h0000_BEEF);

    run_txn(1, 32'h4, 32'h1357_9BDF, 4'h5,
            3, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    run_txn(1, 32'h8, 32'hCAFE_F00D, 4'hF,
            0, 1, 0, 0, 2, 2'b10, 0, 0, 0);
    run_txn(0, 32'h8, 32'h0, 4'hA,
            0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
    run_txn(0, 32'h4, 32'h0, 4'hF,
            0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
    run_txn(0, 32'h0, 32'h0, 4'hF,
            0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    run_txn(0, 32'h0, 32'h0, 4'hF,
            0, 0, 0, 10, 0, 2'b00, 0, 0, 1);

    for (int k = 0; k < 16; k++) begin
      q_wr = 1'($urandom);
      q_a = {28'b0, 2'($urandom), 2'b00};
      q_d = $urandom;
      q_s = 4'($urandom);
      q_br = 2'($urandom);
      q_same = 1'($urandom);
      run_txn(q_wr, q_a, q_d, q_s,
              $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), q_br, q_same, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
